// File: rtl/gsr_pur_assign_if.sv
// Global reset nets shared between the generator and the primitives it feeds:
// the user GSR request in, the active-low PUR/GSR nets out.
interface gsr_pur_assign_if;
  logic GSR_N;
  logic GSR_sig;
  logic PUR_sig;

  modport master (
    output GSR_N,
    input  GSR_sig,
    input  PUR_sig
  );

  modport slave (
    input  GSR_N,
    output GSR_sig,
    output PUR_sig
  );
endinterface

// File: rtl/gsr_pur_assign.sv
// Power-up reset and global set/reset generator. PUR_sig releases a fixed number
// of cycles after RST; GSR_sig adds a synchronised, pulse-stretched user request.
module gsr_pur_assign #(
  parameter int unsigned PUR_CYCLES      = 16,
  parameter string       GSR_ENABLE      = "ENABLED",
  parameter int unsigned GSR_SYNC_STAGES = 2,
  parameter int unsigned GSR_STRETCH     = 4
) (
  input logic             SCLK,
  input logic             RST,
  gsr_pur_assign_if.slave gsr_if
);

  localparam int unsigned PW = $clog2(PUR_CYCLES + 1);
  localparam int unsigned SW = (GSR_STRETCH > 0) ? $clog2(GSR_STRETCH + 1) : 1;
  localparam logic [PW-1:0] PUR_MAX      = PW'(PUR_CYCLES);
  localparam logic [SW-1:0] STRETCH_LOAD = SW'(GSR_STRETCH);
  localparam bit            GSR_EN       = (GSR_ENABLE == "ENABLED");

  logic [PW-1:0]              pur_cnt_q, pur_cnt_d;
  logic                       pur_q, pur_d;
  logic [GSR_SYNC_STAGES-1:0] sync_q, sync_d;
  logic                       sync_out;
  logic [SW-1:0]              stretch_q, stretch_d;
  logic                       gsr_q, gsr_d;

  // Synchroniser chain: stage 0 samples the asynchronous request.
  assign sync_d[0] = gsr_if.GSR_N;

  genvar gi;
  generate
    for (gi = 1; gi < GSR_SYNC_STAGES; gi++) begin : g_sync
      assign sync_d[gi] = sync_q[gi-1];
    end
  endgenerate

  assign sync_out = sync_q[GSR_SYNC_STAGES-1];

  always_comb begin
    pur_cnt_d = pur_cnt_q;
    if (pur_cnt_q < PUR_MAX) begin
      pur_cnt_d = pur_cnt_q + PW'(1);
    end
    pur_d = (pur_cnt_d == PUR_MAX);

    // Any low sample reloads the stretch, so overlapping requests extend the low.
    stretch_d = stretch_q;
    if (!sync_out) begin
      stretch_d = STRETCH_LOAD;
    end else if (stretch_q != '0) begin
      stretch_d = stretch_q - SW'(1);
    end

    if (GSR_EN) begin
      gsr_d = pur_d & sync_out & (stretch_q == '0);
    end else begin
      gsr_d = pur_d;
    end
  end

  always_ff @(posedge SCLK) begin
    if (RST) begin
      pur_cnt_q <= '0;
      pur_q     <= 1'b0;
      sync_q    <= '0;
      stretch_q <= STRETCH_LOAD;
      gsr_q     <= 1'b0;
    end else begin
      pur_cnt_q <= pur_cnt_d;
      pur_q     <= pur_d;
      sync_q    <= sync_d;
      stretch_q <= stretch_d;
      gsr_q     <= gsr_d;
    end
  end

  assign gsr_if.PUR_sig = pur_q;
  assign gsr_if.GSR_sig = gsr_q;

endmodule

// File: tb/tb_gsr_pur_assign.sv
// Directed bench for gsr_pur_assign: a default instance, a no-stretch instance
// and a GSR-disabled instance share clock and reset.
module tb_gsr_pur_assign;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  gsr_pur_assign_if a_if ();
  gsr_pur_assign_if b_if ();
  gsr_pur_assign_if c_if ();

  gsr_pur_assign #(
    .PUR_CYCLES(16), .GSR_ENABLE("ENABLED"), .GSR_SYNC_STAGES(2), .GSR_STRETCH(4)
  ) dut_a (
    .SCLK(clk), .RST(rst), .gsr_if(a_if)
  );

  gsr_pur_assign #(
    .PUR_CYCLES(4), .GSR_ENABLE("ENABLED"), .GSR_SYNC_STAGES(2), .GSR_STRETCH(0)
  ) dut_b (
    .SCLK(clk), .RST(rst), .gsr_if(b_if)
  );

  gsr_pur_assign #(
    .PUR_CYCLES(4), .GSR_ENABLE("DISABLED"), .GSR_SYNC_STAGES(2), .GSR_STRETCH(4)
  ) dut_c (
    .SCLK(clk), .RST(rst), .gsr_if(c_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    a_if.GSR_N = 1'b1;
    b_if.GSR_N = 1'b1;
    c_if.GSR_N = 1'b1;
    repeat (3) tick();
    checks++;
    if (a_if.PUR_sig !== 1'b0) begin
      failures++;
      $display("FAIL reset_a_pur got=%b want=0", a_if.PUR_sig);
    end
    checks++;
    if (a_if.GSR_sig !== 1'b0) begin
      failures++;
      $display("FAIL reset_a_gsr got=%b want=0", a_if.GSR_sig);
    end
    checks++;
    if (b_if.PUR_sig !== 1'b0 || b_if.GSR_sig !== 1'b0) begin
      failures++;
      $display("FAIL reset_b got=%b%b want=00", b_if.PUR_sig, b_if.GSR_sig);
    end
    checks++;
    if (c_if.PUR_sig !== 1'b0 || c_if.GSR_sig !== 1'b0) begin
      failures++;
      $display("FAIL reset_c got=%b%b want=00", c_if.PUR_sig, c_if.GSR_sig);
    end
    $display("test_reset done");
  endtask

  // Edge k=1 is the first edge sampling RST=0.
  task automatic test_pur_release;
    logic exp_a;
    logic exp_b;
    rst = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      exp_a = (k >= 16);
      exp_b = (k >= 4);
      checks++;
      if (a_if.PUR_sig !== exp_a) begin
        failures++;
        $display("FAIL pur_release_a_pur edge=%0d got=%b want=%b", k, a_if.PUR_sig, exp_a);
      end
      checks++;
      if (a_if.GSR_sig !== exp_a) begin
        failures++;
        $display("FAIL pur_release_a_gsr edge=%0d got=%b want=%b", k, a_if.GSR_sig, exp_a);
      end
      checks++;
      if (b_if.PUR_sig !== exp_b || b_if.GSR_sig !== exp_b) begin
        failures++;
        $display("FAIL pur_release_b edge=%0d got=%b%b want=%b%b", k,
                 b_if.PUR_sig, b_if.GSR_sig, exp_b, exp_b);
      end
      checks++;
      if (c_if.PUR_sig !== exp_b || c_if.GSR_sig !== exp_b) begin
        failures++;
        $display("FAIL pur_release_c edge=%0d got=%b%b want=%b%b", k,
                 c_if.PUR_sig, c_if.GSR_sig, exp_b, exp_b);
      end
    end
    $display("test_pur_release done");
  endtask

  // GSR_N sampled low at edges 0..2: GSR_sig low at edges 2..8, high from 9.
  task automatic test_gsr_pulse;
    logic exp;
    for (int k = 0; k <= 11; k++) begin
      a_if.GSR_N = (k <= 2) ? 1'b0 : 1'b1;
      tick();
      exp = !(k >= 2 && k <= 8);
      checks++;
      if (a_if.GSR_sig !== exp) begin
        failures++;
        $display("FAIL gsr_pulse_gsr edge=%0d got=%b want=%b", k, a_if.GSR_sig, exp);
      end
      checks++;
      if (a_if.PUR_sig !== 1'b1) begin
        failures++;
        $display("FAIL gsr_pulse_pur edge=%0d got=%b want=1", k, a_if.PUR_sig);
      end
    end
    a_if.GSR_N = 1'b1;
    $display("test_gsr_pulse done");
  endtask

  // One-cycle pulse with no stretch: GSR_sig low at edge 2 only.
  task automatic test_no_stretch;
    logic exp;
    for (int k = 0; k <= 5; k++) begin
      b_if.GSR_N = (k == 0) ? 1'b0 : 1'b1;
      tick();
      exp = (k != 2);
      checks++;
      if (b_if.GSR_sig !== exp) begin
        failures++;
        $display("FAIL no_stretch_gsr edge=%0d got=%b want=%b", k, b_if.GSR_sig, exp);
      end
    end
    b_if.GSR_N = 1'b1;
    $display("test_no_stretch done");
  endtask

  // Low at edges 0..2, re-asserted at edge 5 while the stretch count is 2;
  // final rise sampled at edge 6, so GSR_sig stays low 2..11 and rises at 12.
  task automatic test_reassert;
    logic exp;
    for (int k = 0; k <= 15; k++) begin
      a_if.GSR_N = (k <= 2 || k == 5) ? 1'b0 : 1'b1;
      tick();
      exp = !(k >= 2 && k <= 11);
      checks++;
      if (a_if.GSR_sig !== exp) begin
        failures++;
        $display("FAIL reassert_gsr edge=%0d got=%b want=%b", k, a_if.GSR_sig, exp);
      end
    end
    a_if.GSR_N = 1'b1;
    $display("test_reassert done");
  endtask

  task automatic test_reset_mid;
    logic exp;
    checks++;
    if (a_if.GSR_sig !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_pre_gsr got=%b want=1", a_if.GSR_sig);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (a_if.PUR_sig !== 1'b0 || a_if.GSR_sig !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_edge got=%b%b want=00", a_if.PUR_sig, a_if.GSR_sig);
    end
    for (int k = 1; k <= 18; k++) begin
      tick();
      exp = (k >= 16);
      checks++;
      if (a_if.PUR_sig !== exp || a_if.GSR_sig !== exp) begin
        failures++;
        $display("FAIL reset_mid_release edge=%0d got=%b%b want=%b%b", k,
                 a_if.PUR_sig, a_if.GSR_sig, exp, exp);
      end
    end
    $display("test_reset_mid done");
  endtask

  // GSR_N toggles on both the disabled and the default instance; neither PUR
  // may move, and the disabled GSR_sig must follow PUR_sig exactly.
  task automatic test_disabled;
    logic [23:0] pat;
    logic        exp_c;
    logic        exp_a;
    pat = 24'hA371CA;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (c_if.PUR_sig !== 1'b0 || c_if.GSR_sig !== 1'b0) begin
      failures++;
      $display("FAIL disabled_reset got=%b%b want=00", c_if.PUR_sig, c_if.GSR_sig);
    end
    for (int k = 1; k <= 24; k++) begin
      c_if.GSR_N = pat[k-1];
      a_if.GSR_N = pat[k-1];
      tick();
      exp_c = (k >= 4);
      exp_a = (k >= 16);
      checks++;
      if (c_if.PUR_sig !== exp_c || c_if.GSR_sig !== exp_c) begin
        failures++;
        $display("FAIL disabled_c edge=%0d got=%b%b want=%b%b", k,
                 c_if.PUR_sig, c_if.GSR_sig, exp_c, exp_c);
      end
      checks++;
      if (a_if.PUR_sig !== exp_a) begin
        failures++;
        $display("FAIL disabled_a_pur edge=%0d got=%b want=%b", k, a_if.PUR_sig, exp_a);
      end
      if (k < 16) begin
        checks++;
        if (a_if.GSR_sig !== 1'b0) begin
          failures++;
          $display("FAIL disabled_a_dominance edge=%0d got=%b want=0", k, a_if.GSR_sig);
        end
      end
    end
    a_if.GSR_N = 1'b1;
    c_if.GSR_N = 1'b1;
    $display("test_disabled done");
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    a_if.GSR_N = 1'b1;
    b_if.GSR_N = 1'b1;
    c_if.GSR_N = 1'b1;
    test_reset();
    test_pur_release();
    test_gsr_pulse();
    test_no_stretch();
    test_reassert();
    test_reset_mid();
    test_disabled();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
